rd_ctrl_mc: RTL
===============

Name: rd_ctrl_mc

Overview:
Multi-channel cache read controller; successor to the single-port read FSM. Arbitrates NUM_CH requester read channels round-robin onto one list lookup / data-memory path, resolves hits, and services misses (conflict check, allocate, optional dirty-victim writeback, line fill, list update). Hit data returns in order through a channel-ID FIFO, so a new request may start while earlier read data is still in flight.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data word width
LIST_DEPTH, 4, cache lines; TAG_W = $clog2(LIST_DEPTH)
LIST_WIDTH, 32, words per line; OFF_W = $clog2(LIST_WIDTH*DATA_W/8), WB_W = $clog2(DATA_W/8)
NUM_CH, 2, requester channels (>=1); CH_W = max(1,$clog2(NUM_CH))
RSP_DEPTH, 4, outstanding mem-read ID FIFO depth (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
ch_rd_valid  in  NUM_CH  per-channel request valid
ch_rd_ready  out  NUM_CH  per-channel accept
ch_rd_addr  in  NUM_CH*ADDR_W  packed byte addresses, ch0 in LSBs
ch_rd_data  out  DATA_W  shared read data
ch_rd_data_valid  out  NUM_CH  one-hot data valid
ch_rd_done  out  NUM_CH  one-hot done pulse
lk_req / lk_gnt  out / in  1 / 1  list access handshake
lk_cmd  out  3  001 lookup, 010 allocate, 011 update-valid
lk_index  out  ADDR_W  line address
lk_tag  out  TAG_W  tag for update
lk_status  in  3  response status
lk_tag_rsp  in  TAG_W  returned tag
lk_victim_index  in  ADDR_W  victim line address (allocate)
own_status / own_addr  out  3 / ADDR_W  conflict status published to peer controller
peer_status / peer_addr  in  3 / ADDR_W  peer controller status
fetch_req / fetch_gnt / fetch_done  out / in / in  1 each  line mover handshake
fetch_cmd  out  2  00 writeback, 01 fill
fetch_tag / fetch_addr  out  TAG_W / ADDR_W  line tag / line address
mem_ren / mem_rready  out / in  1 / 1  data memory read handshake
mem_raddr  out  TAG_W+OFF_W-WB_W  {tag, word offset}
mem_rdata / mem_rdata_valid  in  DATA_W / 1  read return
rsp_err  out  1  sticky: return with empty ID FIFO

Behaviour:
- Reset (async, rst_n low): state IDLE, rr pointer 0, FIFO empty, rsp_err 0, all outputs 0. Reset mid-miss abandons the transaction; no cleanup traffic.
- Line address = addr with low OFF_W bits zeroed; drives lk_index, own_addr, fill fetch_addr.
- IDLE: winner = first valid channel at/after rr pointer. ch_rd_ready[winner]=1 combinationally; all others 0. On handshake, capture addr and channel ID; go to LOOKUP. Pointer advances to winner+1 mod NUM_CH at handshake.
- LOOKUP: lk_req=1, cmd 001, until lk_gnt. Status 001/010/011/110 = hit: latch lk_tag_rsp, go to HIT_RD. Status 000 = miss: go to CHECK_CONFLICT. Status 100 = line busy: go to WAIT_CONFLICT.
- CHECK_CONFLICT (1 cycle, own_status=001): if peer_status is 001 or 010 and peer_addr==own_addr, go to WAIT_CONFLICT; else go to ALLOCATE.
- WAIT_CONFLICT: own_status=100. When peer_status!=010, return to LOOKUP (full retry).
- ALLOCATE: lk_req, cmd 010, until gnt. Latch tag and victim index. Status 010 (dirty victim) goes to WB_REQ; any other status goes to FILL_REQ.
- WB_REQ: fetch_req, cmd 00, addr=victim, until gnt; then WB_WAIT, which exits to FILL_REQ on fetch_done.
- FILL_REQ: fetch_req, cmd 01, addr=line, until gnt; then FILL_WAIT, which exits to UPDATE on fetch_done.
- UPDATE: lk_req, cmd 011, lk_tag=latched tag, until gnt; then HIT_RD.
- fetch_tag is always the latched tag.
- own_status=010 from ALLOCATE through UPDATE, and in HIT_RD when reached via a miss. Otherwise 000 outside the conflict states.
- HIT_RD: mem_ren=1 while FIFO not full; mem_raddr={tag, addr[OFF_W-1:WB_W]}. On mem_ren&&mem_rready, push channel ID and return to IDLE. ch_rd_done[ch] pulses one cycle later (registered).
- Return path: mem_rdata_valid pops FIFO head; ch_rd_data_valid[head]=1 same cycle; ch_rd_data=mem_rdata.
- Same-cycle push and pop is legal, including at full.
- mem_rdata_valid with empty FIFO: ignored, rsp_err set (sticky until reset).
- NUM_CH=1: arbiter degenerates to pass-through; CH_W=1.

Test Plan:
- Single hit, ch0 addr 0x104, lk_status 001, tag 2 -> mem_raddr {2, 0x01}; data 0xA5 -> ch_rd_data_valid=01; done pulse next cycle after mem handshake.
- ch0 and ch1 valid together twice, both hits -> grants ch0, ch1, ch0, ch1; data_valid order matches grant order.
- Miss with clean victim: lookup 000, allocate status 001, tag 3 -> one fetch_req cmd 01 addr 0x100. Then update cmd 011 tag 3, then mem read from tag 3.
- Miss with dirty victim: allocate status 010, victim 0x300 -> fetch cmd 00 addr 0x300, then cmd 01 addr 0x100, in order.
- Conflict: peer_status 010 with equal addr at CHECK_CONFLICT -> own_status 100 held until peer_status 000, then lk_cmd 001 reissued.
- RSP_DEPTH=4 with mem_rdata_valid withheld: four hits issue; fifth holds mem_ren low until one return. A stray return with empty FIFO sets rsp_err.

Source files
------------

// File: rtl/rd_ctrl_mc.sv
// Multi-channel cache read controller: round-robin arbiter, lookup, miss service and in-order return via channel-ID FIFO.
// Latency: done one cycle after mem read handshake; backpressure: ch_rd_ready only in IDLE, mem_ren held low while ID FIFO full.
module rd_ctrl_mc #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LIST_DEPTH = 4,
    parameter int LIST_WIDTH = 32,
    parameter int NUM_CH     = 2,
    parameter int RSP_DEPTH  = 4,
    localparam int TAG_W     = $clog2(LIST_DEPTH),
    localparam int OFF_W     = $clog2(LIST_WIDTH * DATA_W / 8),
    localparam int WB_W      = $clog2(DATA_W / 8),
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int MRA_W     = TAG_W + OFF_W - WB_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_rd_valid,
    output logic [NUM_CH-1:0]        ch_rd_ready,
    input  logic [NUM_CH*ADDR_W-1:0] ch_rd_addr,
    output logic [DATA_W-1:0]        ch_rd_data,
    output logic [NUM_CH-1:0]        ch_rd_data_valid,
    output logic [NUM_CH-1:0]        ch_rd_done,
    output logic                     lk_req,
    input  logic                     lk_gnt,
    output logic [2:0]               lk_cmd,
    output logic [ADDR_W-1:0]        lk_index,
    output logic [TAG_W-1:0]         lk_tag,
    input  logic [2:0]               lk_status,
    input  logic [TAG_W-1:0]         lk_tag_rsp,
    input  logic [ADDR_W-1:0]        lk_victim_index,
    output logic [2:0]               own_status,
    output logic [ADDR_W-1:0]        own_addr,
    input  logic [2:0]               peer_status,
    input  logic [ADDR_W-1:0]        peer_addr,
    output logic                     fetch_req,
    input  logic                     fetch_gnt,
    input  logic                     fetch_done,
    output logic [1:0]               fetch_cmd,
    output logic [TAG_W-1:0]         fetch_tag,
    output logic [ADDR_W-1:0]        fetch_addr,
    output logic                     mem_ren,
    input  logic                     mem_rready,
    output logic [MRA_W-1:0]         mem_raddr,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_rdata_valid,
    output logic                     rsp_err
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_LOOKUP    = 4'd1;
    localparam logic [3:0] S_CHK_CONF  = 4'd2;
    localparam logic [3:0] S_WAIT_CONF = 4'd3;
    localparam logic [3:0] S_ALLOCATE  = 4'd4;
    localparam logic [3:0] S_WB_REQ    = 4'd5;
    localparam logic [3:0] S_WB_WAIT   = 4'd6;
    localparam logic [3:0] S_FILL_REQ  = 4'd7;
    localparam logic [3:0] S_FILL_WAIT = 4'd8;
    localparam logic [3:0] S_UPDATE    = 4'd9;
    localparam logic [3:0] S_HIT_RD    = 4'd10;

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [3:0]        state_q, state_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [ADDR_W-1:0] victim_q, victim_d;
    logic              miss_q, miss_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic              rsp_err_q, rsp_err_d;
    logic [CH_W-1:0]   fifo_q [RSP_DEPTH];
    logic [CH_W-1:0]   fifo_d [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [CH_W-1:0]   win;
    logic              any_vld;
    logic [ADDR_W-1:0] line_addr;
    logic              fifo_full, fifo_empty, push, pop;
    logic [CH_W-1:0]   head;

    assign line_addr  = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign lk_index   = line_addr;
    assign own_addr   = line_addr;
    assign lk_tag     = tag_q;
    assign fetch_tag  = tag_q;
    assign mem_raddr  = {tag_q, addr_q[OFF_W-1:WB_W]};
    assign ch_rd_data = mem_rdata;
    assign ch_rd_done = done_q;
    assign rsp_err    = rsp_err_q;

    assign fifo_full  = (cnt_q == CNT_W'(RSP_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign head       = fifo_q[rd_ptr_q];
    assign mem_ren    = (state_q == S_HIT_RD) && !fifo_full;
    assign push       = mem_ren && mem_rready;
    assign pop        = mem_rdata_valid && !fifo_empty;

    // Scan from the far end back towards rr_q so the nearest valid channel wins.
    always_comb begin
        win     = rr_q;
        any_vld = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_rd_valid[(int'(rr_q) + i) % NUM_CH]) begin
                win     = CH_W'((int'(rr_q) + i) % NUM_CH);
                any_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        addr_d      = addr_q;
        ch_d        = ch_q;
        tag_d       = tag_q;
        victim_d    = victim_q;
        miss_d      = miss_q;
        ch_rd_ready = '0;
        lk_req      = 1'b0;
        lk_cmd      = 3'b000;
        fetch_req   = 1'b0;
        fetch_cmd   = 2'b00;
        fetch_addr  = line_addr;
        own_status  = 3'b000;
        case (state_q)
            S_IDLE: begin
                if (any_vld) begin
                    ch_rd_ready[win] = 1'b1;
                    addr_d  = ch_rd_addr[int'(win)*ADDR_W +: ADDR_W];
                    ch_d    = win;
                    rr_d    = CH_W'((int'(win) + 1) % NUM_CH);
                    miss_d  = 1'b0;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                lk_req = 1'b1;
                lk_cmd = 3'b001;
                if (lk_gnt) begin
                    case (lk_status)
                        3'b001, 3'b010, 3'b011, 3'b110: begin
                            tag_d   = lk_tag_rsp;
                            state_d = S_HIT_RD;
                        end
                        3'b100:  state_d = S_WAIT_CONF;
                        default: state_d = S_CHK_CONF;
                    endcase
                end
            end
            S_CHK_CONF: begin
                own_status = 3'b001;
                if ((peer_status == 3'b001 || peer_status == 3'b010) && peer_addr == line_addr)
                    state_d = S_WAIT_CONF;
                else
                    state_d = S_ALLOCATE;
            end
            S_WAIT_CONF: begin
                own_status = 3'b100;
                if (peer_status != 3'b010) state_d = S_LOOKUP;
            end
            S_ALLOCATE: begin
                own_status = 3'b010;
                lk_req     = 1'b1;
                lk_cmd     = 3'b010;
                if (lk_gnt) begin
                    tag_d    = lk_tag_rsp;
                    victim_d = lk_victim_index;
                    miss_d   = 1'b1;
                    state_d  = (lk_status == 3'b010) ? S_WB_REQ : S_FILL_REQ;
                end
            end
            S_WB_REQ: begin
                own_status = 3'b010;
                fetch_req  = 1'b1;
                fetch_cmd  = 2'b00;
                fetch_addr = victim_q;
                if (fetch_gnt) state_d = S_WB_WAIT;
            end
            S_WB_WAIT: begin
                own_status = 3'b010;
                if (fetch_done) state_d = S_FILL_REQ;
            end
            S_FILL_REQ: begin
                own_status = 3'b010;
                fetch_req  = 1'b1;
                fetch_cmd  = 2'b01;
                if (fetch_gnt) state_d = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                own_status = 3'b010;
                if (fetch_done) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                own_status = 3'b010;
                lk_req     = 1'b1;
                lk_cmd     = 3'b011;
                if (lk_gnt) state_d = S_HIT_RD;
            end
            S_HIT_RD: begin
                own_status = miss_q ? 3'b010 : 3'b000;
                if (push) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Return path: FIFO head steers the shared data bus to its requester.
    always_comb begin
        fifo_d = fifo_q;
        if (push) fifo_d[wr_ptr_q] = ch_q;
        wr_ptr_d  = wr_ptr_q + PTR_W'(push);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        cnt_d     = cnt_q + CNT_W'(push) - CNT_W'(pop);
        rsp_err_d = rsp_err_q | (mem_rdata_valid && fifo_empty);
        for (int i = 0; i < NUM_CH; i++) begin
            ch_rd_data_valid[i] = pop && (head == CH_W'(i));
            done_d[i]           = push && (ch_q == CH_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rr_q      <= '0;
            addr_q    <= '0;
            ch_q      <= '0;
            tag_q     <= '0;
            victim_q  <= '0;
            miss_q    <= 1'b0;
            done_q    <= '0;
            rsp_err_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            addr_q    <= addr_d;
            ch_q      <= ch_d;
            tag_q     <= tag_d;
            victim_q  <= victim_d;
            miss_q    <= miss_d;
            done_q    <= done_d;
            rsp_err_q <= rsp_err_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            fifo_q    <= fifo_d;
        end
    end

endmodule
